branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the branch-decoder output: JIRL, BEQ, BNE, BLT, BGE, BLTU and BGEU (aluop/alusel/imm, operands, PC, prediction).
- Evaluates the condition, computes the target and the link value, and detects mispredictions against the frontend prediction.
- Registers the result in a one-entry valid/ready output stage and issues a one-cycle redirect.
- After a redirect it discards younger instructions until the pipeline flush arrives.

Parameters:
- ADDR_WIDTH, 32, PC/target width
- DATA_WIDTH, 32, operand/immediate/link width
- ALU_OP_WIDTH, 8, aluop width (`EXE_*_OP` encodings)
- ALU_SEL_WIDTH, 3, alusel width (`EXE_RES_*` encodings)
- GPR_NUM, 32, register count; write address width is $clog2(GPR_NUM)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush_i  in  1  pipeline flush from the backend
- in_valid_i  in  1  decoded instruction valid
- in_ready_o  out  1  unit can accept an instruction
- pc_i  in  ADDR_WIDTH  instruction PC
- aluop_i  in  ALU_OP_WIDTH  operation
- alusel_i  in  ALU_SEL_WIDTH  result class
- rj_data_i  in  DATA_WIDTH  rj operand
- rd_data_i  in  DATA_WIDTH  rd operand (second compare source)
- imm_i  in  DATA_WIDTH  sign-extended imm16<<2
- wb_valid_i  in  1  GPR write request
- wb_addr_i  in  $clog2(GPR_NUM)  GPR write address
- pred_taken_i  in  1  frontend predicted taken
- pred_target_i  in  ADDR_WIDTH  frontend predicted target
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- out_pc_o  out  ADDR_WIDTH  registered PC
- taken_o  out  1  actual taken
- link_data_o  out  DATA_WIDTH  pc+4
- wb_valid_o  out  1  registered wb_valid_i
- wb_addr_o  out  $clog2(GPR_NUM)  registered wb_addr_i
- redirect_valid_o  out  1  one-cycle redirect pulse
- redirect_pc_o  out  ADDR_WIDTH  correct next PC

Behaviour:
- Reset: all outputs and registers are 0, except in_ready_o=1; the FSM enters RUN.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i in RUN; in_ready_o=1 in WAIT_FLUSH.
  - An instruction is accepted when in_valid_i && in_ready_o; the result is registered and out_valid_o is set on the next cycle (latency 1).
  - out_valid_o clears when accepted (out_ready_i) with no new input.
  - Registered outputs hold while out_valid_o && !out_ready_i.
- Jump class: an instruction is a jump only if alusel_i==`EXE_RES_JUMP`.
- Conditions:
  - BEQ: rj==rd; BNE: rj!=rd.
  - BLT/BGE: signed rj<rd and its complement.
  - BLTU/BGEU: unsigned rj<rd and its complement.
  - JIRL: always taken.
  - Unknown aluop with the jump class: not taken.
  - Non-jump class: taken=0.
- Target: JIRL uses rj_data_i+imm_i; other branches use pc_i+imm_i. Additions are modulo 2^ADDR_WIDTH (wrap, no flag); link = pc_i+4, also wrapping.
- Mispredict, on the accepted instruction only: taken != pred_taken_i, or (taken && target != pred_target_i). A non-jump instruction with pred_taken_i=1 is a mispredict with redirect_pc = pc+4.
- Redirect: on mispredict, redirect_valid_o=1 for exactly one cycle, coincident with out_valid_o rising. redirect_pc_o = taken ? target : pc+4 and holds until the next redirect.
- FSM:
  - RUN -> WAIT_FLUSH on an accepted mispredict.
  - WAIT_FLUSH: inputs are accepted and dropped (no out_valid_o, no redirect); the already-registered result still drains via out_ready_i.
  - WAIT_FLUSH -> RUN on flush_i.
- flush_i has the highest priority, in any state:
  - next cycle: out_valid_o=0, redirect_valid_o=0, state RUN;
  - a same-cycle input is dropped.
  - A flush in the same cycle as a mispredicting accept suppresses the redirect.
- Simultaneous drain and accept in RUN: the new result replaces the old one in the same edge; no bubble.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- With the macro, outputs perf_branch_cnt_o[31:0] and perf_mispred_cnt_o[31:0] are present:
  - perf_branch_cnt_o increments once per accepted jump-class instruction in RUN;
  - perf_mispred_cnt_o increments once per issued redirect;
  - both saturate at 0xFFFFFFFF, reset to 0, and are unaffected by flush_i.
- Without the macro, those ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. BEQ, pc=0x1c000000, rj=rd=5, imm=0x40, pred_taken=1, pred_target=0x1c000040 -> next cycle out_valid=1, taken=1, no redirect.
2. BLT, rj=0xFFFFFFFF, rd=1, pred_taken=0 -> taken=1 (signed), redirect_valid one cycle, redirect_pc=pc+imm. BLTU with the same operands -> taken=0, no redirect.
3. JIRL, rj=0x1c001000, imm=0x8, pc=0x1c000010, pred_target=0x1c001000 -> mispredict, redirect_pc=0x1c001008, link_data=0x1c000014, wb_valid/wb_addr forwarded.
4. After test 3's redirect, feed 3 instructions -> all accepted, none output. flush_i -> RUN; the next BNE (rj=1, rd=2) outputs taken=1.
5. out_ready_i=0 for 4 cycles with out_valid=1 -> in_ready_o=0 and outputs stable; out_ready_i=1 with in_valid=1 -> back-to-back result, no bubble.
6. Reset asserted mid-transfer with out_valid=1 -> all outputs 0 immediately (async). With BRU_PERF_CNT_EN, counters read 0 after reset and 2/1 after two branches (one mispredicted).

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Execute-stage branch/jump resolution with a one-entry output
//               stage, misprediction redirect and post-redirect squash.
//               Optional perf counters: define BRU_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef EXE_RES_JUMP
`define EXE_RES_JUMP 3'b101
`endif
`ifndef EXE_JIRL_OP
`define EXE_JIRL_OP  8'h2C
`endif
`ifndef EXE_BEQ_OP
`define EXE_BEQ_OP   8'h2D
`endif
`ifndef EXE_BNE_OP
`define EXE_BNE_OP   8'h2E
`endif
`ifndef EXE_BLT_OP
`define EXE_BLT_OP   8'h2F
`endif
`ifndef EXE_BGE_OP
`define EXE_BGE_OP   8'h30
`endif
`ifndef EXE_BLTU_OP
`define EXE_BLTU_OP  8'h31
`endif
`ifndef EXE_BGEU_OP
`define EXE_BGEU_OP  8'h32
`endif

module branch_resolve_unit #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ALU_OP_WIDTH  = 8,
    parameter int ALU_SEL_WIDTH = 3,
    parameter int GPR_NUM       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_WIDTH-1:0]      pc_i,
    input  logic [ALU_OP_WIDTH-1:0]    aluop_i,
    input  logic [ALU_SEL_WIDTH-1:0]   alusel_i,
    input  logic [DATA_WIDTH-1:0]      rj_data_i,
    input  logic [DATA_WIDTH-1:0]      rd_data_i,
    input  logic [DATA_WIDTH-1:0]      imm_i,
    input  logic                       wb_valid_i,
    input  logic [$clog2(GPR_NUM)-1:0] wb_addr_i,
    input  logic                       pred_taken_i,
    input  logic [ADDR_WIDTH-1:0]      pred_target_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ADDR_WIDTH-1:0]      out_pc_o,
    output logic                       taken_o,
    output logic [DATA_WIDTH-1:0]      link_data_o,
    output logic                       wb_valid_o,
    output logic [$clog2(GPR_NUM)-1:0] wb_addr_o,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]                perf_branch_cnt_o,
    output logic [31:0]                perf_mispred_cnt_o,
`endif
    output logic                       redirect_valid_o,
    output logic [ADDR_WIDTH-1:0]      redirect_pc_o
);

    localparam logic [ALU_SEL_WIDTH-1:0] c_RES_JUMP = ALU_SEL_WIDTH'(`EXE_RES_JUMP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_JIRL  = ALU_OP_WIDTH'(`EXE_JIRL_OP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_BEQ   = ALU_OP_WIDTH'(`EXE_BEQ_OP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_BNE   = ALU_OP_WIDTH'(`EXE_BNE_OP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_BLT   = ALU_OP_WIDTH'(`EXE_BLT_OP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_BGE   = ALU_OP_WIDTH'(`EXE_BGE_OP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_BLTU  = ALU_OP_WIDTH'(`EXE_BLTU_OP);
    localparam logic [ALU_OP_WIDTH-1:0]  c_OP_BGEU  = ALU_OP_WIDTH'(`EXE_BGEU_OP);

    typedef enum logic [0:0] {
        S_RUN        = 1'b0,
        S_WAIT_FLUSH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                       r_out_valid;
    logic [ADDR_WIDTH-1:0]      r_out_pc;
    logic                       r_taken;
    logic [DATA_WIDTH-1:0]      r_link_data;
    logic                       r_wb_valid;
    logic [$clog2(GPR_NUM)-1:0] r_wb_addr;
    logic                       r_redirect_valid;
    logic [ADDR_WIDTH-1:0]      r_redirect_pc;

    logic                  w_is_jump;
    logic                  w_cond;
    logic                  w_taken;
    logic                  w_mispredict;
    logic                  w_run_ready;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;

    // ---------------- condition and target evaluation ----------------
    always_comb begin
        w_cond   = 1'b0;
        w_target = pc_i + ADDR_WIDTH'(imm_i);
        case (aluop_i)
            c_OP_JIRL: begin
                w_cond   = 1'b1;
                w_target = ADDR_WIDTH'(rj_data_i) + ADDR_WIDTH'(imm_i);
            end
            c_OP_BEQ:  w_cond = (rj_data_i == rd_data_i);
            c_OP_BNE:  w_cond = (rj_data_i != rd_data_i);
            c_OP_BLT:  w_cond = ($signed(rj_data_i) <  $signed(rd_data_i));
            c_OP_BGE:  w_cond = ($signed(rj_data_i) >= $signed(rd_data_i));
            c_OP_BLTU: w_cond = (rj_data_i <  rd_data_i);
            c_OP_BGEU: w_cond = (rj_data_i >= rd_data_i);
            default:   w_cond = 1'b0;
        endcase
    end

    assign w_is_jump     = (alusel_i == c_RES_JUMP);
    assign w_taken       = w_is_jump && w_cond;
    assign w_pc_plus4    = pc_i + ADDR_WIDTH'(4);
    assign w_mispredict  = (w_taken != pred_taken_i) ||
                           (w_taken && (w_target != pred_target_i));
    assign w_redirect_pc = w_taken ? w_target : w_pc_plus4;

    // In WAIT_FLUSH everything offered is swallowed, so readiness is unconditional.
    assign w_run_ready = !r_out_valid || out_ready_i;
    assign in_ready_o  = (r_state == S_WAIT_FLUSH) || w_run_ready;
    assign w_load      = in_valid_i && (r_state == S_RUN) && w_run_ready && !flush_i;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:        if (w_load && w_mispredict) w_state_nxt = S_WAIT_FLUSH;
            S_WAIT_FLUSH: w_state_nxt = S_WAIT_FLUSH;
            default:      w_state_nxt = S_RUN;
        endcase
        if (flush_i) begin
            w_state_nxt = S_RUN;
        end
    end

    // ---------------- output stage ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid      <= 1'b0;
            r_out_pc         <= '0;
            r_taken          <= 1'b0;
            r_link_data      <= '0;
            r_wb_valid       <= 1'b0;
            r_wb_addr        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            if (flush_i) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= pc_i;
                r_taken     <= w_taken;
                r_link_data <= DATA_WIDTH'(w_pc_plus4);
                r_wb_valid  <= wb_valid_i;
                r_wb_addr   <= wb_addr_i;
                if (w_mispredict) begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= w_redirect_pc;
                end
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o      = r_out_valid;
    assign out_pc_o         = r_out_pc;
    assign taken_o          = r_taken;
    assign link_data_o      = r_link_data;
    assign wb_valid_o       = r_wb_valid;
    assign wb_addr_o        = r_wb_addr;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    // Saturating counters; flush does not disturb them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_load && w_is_jump && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_load && w_mispredict && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign perf_branch_cnt_o  = r_branch_cnt;
    assign perf_mispred_cnt_o = r_mispred_cnt;
`endif

endmodule

`default_nettype wire
